// File: rtl/ddr_port_arbiter.sv
// rtl/ddr_port_arbiter.sv - two-master Avalon-MM arbiter for the shared DDR3 port
//
// Purpose:
//   Shares one DDR controller Avalon-MM slave between two Avalon-MM masters.
//   Grants alternate round-robin.  A grant may be held for up to HOLD_MAX
//   accepted commands while the other master stays idle.  Read responses are
//   steered back to the issuing master through an in-order tag FIFO, because
//   the DDR slave returns reads in issue order.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   m0_*                  master 0 (DRAM read-stream master)
//   m1_*                  master 1 (capture/write-stream or debug master)
//     mN_addr/read/write/writedata   command in
//     mN_waitrequest                 stall out
//     mN_readdata/readdatavalid      routed read response out
//   ddr_*                 DDR controller slave side
//   pending               outstanding read count (0..MAX_PENDING)
//   owner                 current / last grant holder
//   err                   sticky: [0] read+write together, [1] unexpected readdatavalid

module ddr_port_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int MAX_PENDING = 8,
  parameter int HOLD_MAX    = 4
) (
  input  logic                         clk,
  input  logic                         reset,

  input  logic [ADDR_W-1:0]            m0_addr,
  input  logic                         m0_read,
  input  logic                         m0_write,
  input  logic [DATA_W-1:0]            m0_writedata,
  output logic                         m0_waitrequest,
  output logic [DATA_W-1:0]            m0_readdata,
  output logic                         m0_readdatavalid,

  input  logic [ADDR_W-1:0]            m1_addr,
  input  logic                         m1_read,
  input  logic                         m1_write,
  input  logic [DATA_W-1:0]            m1_writedata,
  output logic                         m1_waitrequest,
  output logic [DATA_W-1:0]            m1_readdata,
  output logic                         m1_readdatavalid,

  output logic [ADDR_W-1:0]            ddr_addr,
  output logic                         ddr_read,
  output logic                         ddr_write,
  output logic [DATA_W-1:0]            ddr_writedata,
  input  logic                         ddr_waitrequest,
  input  logic [DATA_W-1:0]            ddr_readdata,
  input  logic                         ddr_readdatavalid,

  output logic [$clog2(MAX_PENDING):0] pending,
  output logic                         owner,
  output logic [1:0]                   err
);

  localparam int PW = $clog2(MAX_PENDING);   // tag FIFO pointer width
  localparam int CW = PW + 1;                // pending counter width
  localparam int HW = $clog2(HOLD_MAX + 1);  // hold counter width

  typedef enum logic {
    S_IDLE = 1'b0,
    S_OWN  = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t          r_state;
  logic            r_owner;
  logic            r_last_served;
  logic [HW-1:0]   r_hold_cnt;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_pending;
  logic [1:0]      r_err;
  logic            r_tag [MAX_PENDING];

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic            w_req0;
  logic            w_req1;
  logic            w_own;
  logic            w_o_read;
  logic            w_o_write;
  logic            w_o_req;
  logic            w_other_req;
  logic [ADDR_W-1:0] w_o_addr;
  logic [DATA_W-1:0] w_o_wdata;

  assign w_req0      = m0_read | m0_write;
  assign w_req1      = m1_read | m1_write;
  assign w_own       = (r_state == S_OWN);
  assign w_o_read    = r_owner ? m1_read      : m0_read;
  assign w_o_write   = r_owner ? m1_write     : m0_write;
  assign w_o_addr    = r_owner ? m1_addr      : m0_addr;
  assign w_o_wdata   = r_owner ? m1_writedata : m0_writedata;
  assign w_o_req     = w_o_read | w_o_write;
  assign w_other_req = r_owner ? w_req0 : w_req1;

  // ---------------------------------------------------------------------------
  // Command path (combinational while a grant is held)
  // ---------------------------------------------------------------------------
  logic            w_full;
  logic            w_empty;
  logic            w_rd_block;
  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  logic            w_head;
  logic [HW-1:0]   w_hold_inc;

  assign w_full     = (r_pending == CW'(MAX_PENDING));
  assign w_empty    = (r_pending == '0);

  // A read issued with no free tag would lose its routing, so the owner is
  // stalled until a response frees an entry.
  assign w_rd_block = w_own & w_o_read & w_full;

  // Read wins when a master raises both strobes; the write is discarded.
  assign ddr_read      = w_own & w_o_read & ~w_full;
  assign ddr_write     = w_own & w_o_write & ~w_o_read;
  assign ddr_addr      = w_own ? w_o_addr  : '0;
  assign ddr_writedata = w_own ? w_o_wdata : '0;

  assign w_accept   = (ddr_read | ddr_write) & ~ddr_waitrequest;
  assign w_push     = w_accept & ddr_read;
  assign w_pop      = ddr_readdatavalid & ~w_empty;
  assign w_head     = r_tag[r_rd_ptr];
  assign w_hold_inc = r_hold_cnt + 1'b1;

  assign m0_waitrequest = (w_own & ~r_owner) ? (ddr_waitrequest | w_rd_block) : 1'b1;
  assign m1_waitrequest = (w_own &  r_owner) ? (ddr_waitrequest | w_rd_block) : 1'b1;

  // ---------------------------------------------------------------------------
  // Response routing: zero latency, steered by the oldest outstanding tag.
  // ---------------------------------------------------------------------------
  assign m0_readdata      = ddr_readdata;
  assign m1_readdata      = ddr_readdata;
  assign m0_readdatavalid = ddr_readdatavalid & ~w_empty & ~w_head;
  assign m1_readdatavalid = ddr_readdatavalid & ~w_empty &  w_head;

  assign pending = r_pending;
  assign owner   = r_owner;
  assign err     = r_err;

  // ---------------------------------------------------------------------------
  // Tag storage: contents need no reset, validity is tracked by r_pending.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_tag[r_wr_ptr] <= r_owner;
    end
  end

  // ---------------------------------------------------------------------------
  // Arbitration FSM, tag pointers, pending count and sticky errors
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_owner       <= 1'b0;
      r_last_served <= 1'b1;   // master 0 wins the first tie
      r_hold_cnt    <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_pending     <= '0;
      r_err         <= 2'b00;
    end else begin
      // Sticky error flags
      if ((m0_read & m0_write) | (m1_read & m1_write)) begin
        r_err[0] <= 1'b1;
      end
      if (ddr_readdatavalid & w_empty) begin
        r_err[1] <= 1'b1;
      end

      // Tag FIFO; MAX_PENDING is a power of two so pointers wrap naturally.
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_pending <= r_pending + 1'b1;
        2'b01:   r_pending <= r_pending - 1'b1;
        default: r_pending <= r_pending;
      endcase

      case (r_state)
        S_IDLE: begin
          r_hold_cnt <= '0;
          if (w_req0 & w_req1) begin
            r_owner <= ~r_last_served;
            r_state <= S_OWN;
          end else if (w_req0) begin
            r_owner <= 1'b0;
            r_state <= S_OWN;
          end else if (w_req1) begin
            r_owner <= 1'b1;
            r_state <= S_OWN;
          end
        end

        S_OWN: begin
          if (w_accept) begin
            // Keep the grant only while the other side is idle and the hold
            // budget is not spent.  If the owner then drops its request the
            // no-accept branch below releases the grant next cycle.
            if (~w_other_req && (w_hold_inc < HW'(HOLD_MAX))) begin
              r_hold_cnt <= w_hold_inc;
            end else begin
              r_state       <= S_IDLE;
              r_last_served <= r_owner;
              r_hold_cnt    <= '0;
            end
          end else if (~w_o_req) begin
            // Owner walked away without a transfer: not counted as served.
            r_state    <= S_IDLE;
            r_hold_cnt <= '0;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
